// File: rtl/prog_clock_divider_pkg.sv
// -----------------------------------------------------------------------------
// prog_clock_divider_pkg
// Shared definitions for the programmable clock divider.
//   mode_e   : output mode encoding (toggle = square wave, pulse = strobe)
//   eff_div  : maps a programmed divisor to the divisor actually used
//              (a divisor of zero behaves as one)
// -----------------------------------------------------------------------------
package prog_clock_divider_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // Evaluated at 32 bits so one function serves every divisor width up to 32;
  // callers cast the result back to their own width.
  function automatic logic [31:0] eff_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/prog_clock_divider_counter.sv
// -----------------------------------------------------------------------------
// prescale_counter
// WIDTH-bit period counter with terminal-count detection.
// Ports:
//   hz100    in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   enable   in   count enable; counter holds when low
//   restart  in   forces the counter back to 0 (mode change / idle load)
//   d        in   effective divisor (never 0)
//   count    out  current counter value
//   term     out  terminal condition: enabled and count == d-1
// -----------------------------------------------------------------------------
module prescale_counter #(
  parameter int WIDTH = 8
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] count,
  output logic             term
);

  // A restart cycle is never a terminal cycle: the period is being abandoned.
  assign term = enable && !restart && (count == d - WIDTH'(1));

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the block order.
  always_ff @(posedge hz100) begin
    if (reset) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable) begin
      count <= term ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// -----------------------------------------------------------------------------
// prog_clock_divider
// Programmable prescaler on the 100 Hz board clock. Produces a 50% square wave
// (toggle mode, period 2*D) or a one-cycle strobe (pulse mode, period D).
// The divisor can be reloaded at runtime; while counting, a new value waits
// in a pending register and is applied only at the period wrap.
//
// Optional build macro: TICK_COUNT_EN adds a 16-bit count of terminal ticks.
//
// Ports:
//   hz100         in   system clock, rising edge
//   reset         in   synchronous active-high reset (dominates everything)
//   enable        in   count enable; state holds when low
//   mode          in   0 = toggle, 1 = pulse
//   div_in        in   new divisor
//   div_load      in   one-cycle load request for div_in
//   clk_out       out  divided output (registered)
//   tick          out  one-cycle terminal strobe (registered)
//   count         out  current counter value
//   div_cur       out  divisor in effect
//   load_pending  out  a divisor waits for the next wrap
//   tick_count    out  [TICK_COUNT_EN only] wrapping count of ticks
// -----------------------------------------------------------------------------
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 50
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_cur,
  output logic             load_pending
`ifdef TICK_COUNT_EN
  ,
  output logic [15:0]      tick_count
`endif
);

  mode_e            mode_q;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] d_eff;
  logic             mode_change;
  logic             idle_load;
  logic             term;

  assign d_eff       = WIDTH'(eff_div(32'(div_cur)));
  assign mode_change = (mode_e'(mode) != mode_q);
  assign idle_load   = div_load && !enable;

  prescale_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .hz100   (hz100),
    .reset   (reset),
    .enable  (enable),
    .restart (mode_change || idle_load),
    .d       (d_eff),
    .count   (count),
    .term    (term)
  );

  // Output registers and mode tracking. mode_q loads the live mode during
  // reset so leaving reset never counts as a mode change.
  always_ff @(posedge hz100) begin
    if (reset) begin
      mode_q  <= mode_e'(mode);
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      mode_q <= mode_e'(mode);
      if (mode_change) begin
        tick    <= 1'b0;
        clk_out <= 1'b0;
      end else if (enable) begin
        tick <= term;
        if (mode_q == MODE_PULSE) begin
          clk_out <= term;
        end else if (term) begin
          clk_out <= ~clk_out;
        end
      end else begin
        tick <= 1'b0;
        if (mode_q == MODE_PULSE) begin
          clk_out <= 1'b0;
        end
      end
    end
  end

  // Divisor handling. A load on a terminal cycle bypasses the pending slot;
  // otherwise, while counting, the value waits until the next wrap so the
  // running period is never cut short or stretched past its end.
  always_ff @(posedge hz100) begin
    if (reset) begin
      div_cur      <= WIDTH'(DEFAULT_DIV);
      pending      <= '0;
      load_pending <= 1'b0;
    end else if (div_load && (!enable || term)) begin
      div_cur      <= div_in;
      load_pending <= 1'b0;
    end else if (div_load) begin
      pending      <= div_in;
      load_pending <= 1'b1;
    end else if (term && load_pending) begin
      div_cur      <= pending;
      load_pending <= 1'b0;
    end
  end

`ifdef TICK_COUNT_EN
  always_ff @(posedge hz100) begin
    if (reset || mode_change) begin
      tick_count <= '0;
    end else if (term) begin
      tick_count <= tick_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prog_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_prog_clock_divider
// Directed scenarios plus a randomized run against a behavioural model of the
// divider. Inputs change 1 time unit after the rising edge; outputs are
// compared at the same point, i.e. away from the active edge.
// -----------------------------------------------------------------------------
module tb_prog_clock_divider;

  localparam int WIDTH       = 8;
  localparam int DEFAULT_DIV = 50;

  logic             hz100 = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] div_in = '0;
  logic             div_load = 1'b0;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div_cur;
  logic             load_pending;
`ifdef TICK_COUNT_EN
  logic [15:0]      tick_count;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model state.
  logic [WIDTH-1:0] m_count, m_div, m_pend;
  logic             m_pend_v, m_mode, m_clk, m_tick;
  logic [15:0]      m_tc;

  prog_clock_divider #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .hz100        (hz100),
    .reset        (reset),
    .enable       (enable),
    .mode         (mode),
    .div_in       (div_in),
    .div_load     (div_load),
    .clk_out      (clk_out),
    .tick         (tick),
    .count        (count),
    .div_cur      (div_cur),
    .load_pending (load_pending)
`ifdef TICK_COUNT_EN
    ,
    .tick_count   (tick_count)
`endif
  );

  always #5 hz100 = ~hz100;

  // One rising edge of behaviour, derived from the divider's rules.
  task automatic model_step();
    logic [WIDTH-1:0] d;
    logic             t, restart;
    if (reset) begin
      m_count = '0; m_clk = 1'b0; m_tick = 1'b0; m_div = WIDTH'(DEFAULT_DIV);
      m_pend = '0; m_pend_v = 1'b0; m_mode = mode; m_tc = '0;
      return;
    end
    d       = (m_div == 0) ? WIDTH'(1) : m_div;
    restart = (mode != m_mode);
    t       = enable && !restart && (m_count == d - 1);
    // divisor bookkeeping
    if (div_load && (!enable || t)) begin
      m_div = div_in; m_pend_v = 1'b0;
    end else if (div_load) begin
      m_pend = div_in; m_pend_v = 1'b1;
    end else if (t && m_pend_v) begin
      m_div = m_pend; m_pend_v = 1'b0;
    end
    // counter and outputs
    if (restart) begin
      m_count = '0; m_tick = 1'b0; m_clk = 1'b0; m_tc = '0;
    end else if (enable) begin
      m_count = t ? '0 : m_count + 1;
      m_tick  = t;
      m_clk   = m_mode ? t : (m_clk ^ t);
      m_tc    = m_tc + 16'(t);
    end else begin
      m_tick = 1'b0;
      if (m_mode) m_clk = 1'b0;
      if (div_load) m_count = '0;
    end
    m_mode = mode;
  endtask

  task automatic step();
    @(posedge hz100);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic idle_load(input logic [WIDTH-1:0] v);
    enable = 1'b0; div_load = 1'b1; div_in = v;
    step();
    div_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; mode = 1'b0; div_load = 1'b0;
    step(); step();
    reset = 1'b0;
    total++; if (count !== 0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL reset_clk_out got=%b exp=0", clk_out); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
    total++; if (div_cur !== WIDTH'(DEFAULT_DIV)) begin bad++; $display("FAIL reset_div_cur got=%0d exp=%0d", div_cur, DEFAULT_DIV); end
    total++; if (load_pending !== 1'b0) begin bad++; $display("FAIL reset_load_pending got=%b exp=0", load_pending); end
  endtask

  // Default divisor in toggle mode: 1 Hz square wave, tick every 50 cycles.
  task automatic test_toggle_default();
    enable = 1'b1; mode = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      step();
      total++; if (count !== WIDTH'(k % 50)) begin bad++; $display("FAIL toggle_count k=%0d got=%0d exp=%0d", k, count, k % 50); end
      total++; if (tick !== (k % 50 == 0)) begin bad++; $display("FAIL toggle_tick k=%0d got=%b exp=%b", k, tick, k % 50 == 0); end
      total++; if (clk_out !== 1'((k / 50) % 2)) begin bad++; $display("FAIL toggle_clk k=%0d got=%b exp=%0d", k, clk_out, (k / 50) % 2); end
    end
    total++; if (div_cur !== 8'd50) begin bad++; $display("FAIL toggle_div_cur got=%0d exp=50", div_cur); end
  endtask

  // Idle load of 4 in pulse mode, then a strobe every 4 cycles.
  task automatic test_pulse_load();
    mode = 1'b1;
    idle_load(8'd4);
    total++; if (div_cur !== 8'd4) begin bad++; $display("FAIL pulse_div_cur got=%0d exp=4", div_cur); end
    total++; if (count !== 0) begin bad++; $display("FAIL pulse_count0 got=%0d exp=0", count); end
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      total++; if (count !== WIDTH'(k % 4)) begin bad++; $display("FAIL pulse_count k=%0d got=%0d exp=%0d", k, count, k % 4); end
      total++; if (tick !== (k % 4 == 0)) begin bad++; $display("FAIL pulse_tick k=%0d got=%b exp=%b", k, tick, k % 4 == 0); end
      total++; if (clk_out !== (k % 4 == 0)) begin bad++; $display("FAIL pulse_clk k=%0d got=%b exp=%b", k, clk_out, k % 4 == 0); end
    end
  endtask

  // Running load is held pending until the D=10 period wraps.
  task automatic test_pending_load();
    idle_load(8'd10);
    enable = 1'b1;
    repeat (3) step();
    total++; if (count !== 8'd3) begin bad++; $display("FAIL pend_pre_count got=%0d exp=3", count); end
    div_load = 1'b1; div_in = 8'd3;
    step();
    div_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (load_pending !== 1'b1) begin bad++; $display("FAIL pend_flag i=%0d got=%b exp=1", i, load_pending); end
      total++; if (div_cur !== 8'd10) begin bad++; $display("FAIL pend_div_hold i=%0d got=%0d exp=10", i, div_cur); end
      step();
    end
    total++; if (load_pending !== 1'b1) begin bad++; $display("FAIL pend_flag_last got=%b exp=1", load_pending); end
    step();
    total++; if (div_cur !== 8'd3) begin bad++; $display("FAIL pend_applied got=%0d exp=3", div_cur); end
    total++; if (load_pending !== 1'b0) begin bad++; $display("FAIL pend_cleared got=%b exp=0", load_pending); end
    total++; if (tick !== 1'b1 || count !== 0) begin bad++; $display("FAIL pend_wrap tick=%b count=%0d exp tick=1 count=0", tick, count); end
    for (int k = 1; k <= 9; k++) begin
      step();
      total++; if (tick !== (k % 3 == 0)) begin bad++; $display("FAIL pend_period k=%0d got=%b exp=%b", k, tick, k % 3 == 0); end
    end
  endtask

  // Divisor 0 acts as 1; disabling freezes count/clk_out and drops tick.
  task automatic test_div_zero();
    mode = 1'b0;
    idle_load(8'd0);
    total++; if (div_cur !== 8'd0) begin bad++; $display("FAIL zero_div_cur got=%0d exp=0", div_cur); end
    enable = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      total++; if (tick !== 1'b1) begin bad++; $display("FAIL zero_tick k=%0d got=%b exp=1", k, tick); end
      total++; if (clk_out !== 1'(k % 2)) begin bad++; $display("FAIL zero_clk k=%0d got=%b exp=%0d", k, clk_out, k % 2); end
    end
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL freeze_tick got=%b exp=0", tick); end
      total++; if (clk_out !== 1'b1) begin bad++; $display("FAIL freeze_clk got=%b exp=1", clk_out); end
      total++; if (count !== 0) begin bad++; $display("FAIL freeze_count got=%0d exp=0", count); end
    end
  endtask

  // Mode flip mid-period restarts the divider.
  task automatic test_mode_flip();
    mode = 1'b0;
    idle_load(8'd50);
    enable = 1'b1;
    repeat (20) step();
    total++; if (count !== 8'd20) begin bad++; $display("FAIL flip_pre_count got=%0d exp=20", count); end
    mode = 1'b1;
    step();
    total++; if (count !== 0) begin bad++; $display("FAIL flip_count got=%0d exp=0", count); end
    total++; if (clk_out !== 1'b0 || tick !== 1'b0) begin bad++; $display("FAIL flip_outs clk=%b tick=%b exp 0 0", clk_out, tick); end
    total++; if (div_cur !== 8'd50) begin bad++; $display("FAIL flip_div_cur got=%0d exp=50", div_cur); end
    for (int k = 1; k <= 100; k++) begin
      step();
      total++; if (tick !== (k % 50 == 0) || clk_out !== tick) begin bad++; $display("FAIL flip_strobe k=%0d tick=%b clk=%b exp=%b", k, tick, clk_out, k % 50 == 0); end
    end
  endtask

  // Reset dominates a simultaneous load.
  task automatic test_reset_with_load();
    idle_load(8'd9);
    enable = 1'b1; reset = 1'b1; div_load = 1'b1; div_in = 8'd7;
    step();
    reset = 1'b0; div_load = 1'b0;
    total++; if (div_cur !== 8'd50) begin bad++; $display("FAIL rstload_div_cur got=%0d exp=50", div_cur); end
    total++; if (load_pending !== 1'b0) begin bad++; $display("FAIL rstload_pending got=%b exp=0", load_pending); end
    total++; if (count !== 0) begin bad++; $display("FAIL rstload_count got=%0d exp=0", count); end
  endtask

  task automatic test_random();
    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 0; k < 600; k++) begin
      reset    = ($urandom_range(0, 199) == 0);
      enable   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      div_load = ($urandom_range(0, 9) == 0);
      div_in   = WIDTH'($urandom_range(0, 12));
      step();
      total++;
      if (count !== m_count || clk_out !== m_clk || tick !== m_tick ||
          div_cur !== m_div || load_pending !== m_pend_v) begin
        bad++;
        $display("FAIL random k=%0d got cnt=%0d clk=%b tick=%b div=%0d lp=%b exp cnt=%0d clk=%b tick=%b div=%0d lp=%b",
                 k, count, clk_out, tick, div_cur, load_pending,
                 m_count, m_clk, m_tick, m_div, m_pend_v);
      end
`ifdef TICK_COUNT_EN
      total++; if (tick_count !== m_tc) begin bad++; $display("FAIL random_tick_count k=%0d got=%0d exp=%0d", k, tick_count, m_tc); end
`endif
    end
    reset = 1'b0; div_load = 1'b0;
  endtask

`ifdef TICK_COUNT_EN
  task automatic test_tick_count();
    mode = 1'b1; enable = 1'b0; div_load = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    idle_load(8'd1);
    enable = 1'b1;
    repeat (65537) step();
    total++; if (tick_count !== 16'd1) begin bad++; $display("FAIL tick_count_wrap got=%0d exp=1", tick_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_toggle_default();
    test_pulse_load();
    test_pending_load();
    test_div_zero();
    test_mode_flip();
    test_reset_with_load();
    test_random();
`ifdef TICK_COUNT_EN
    test_tick_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
